// File: rtl/correlator_window_sequencer.sv
// Window sequencer for one correlator power-sum channel: tracks accepted samples through the
// preadd + DSP cascade with a token shift register and drives the stage/accumulator controls.
module correlator_window_sequencer #(
    parameter int NSTAGES      = 6,
    parameter int PIPE_LATENCY = 7,
    parameter int WINBITS      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               START,
    input  logic               ABORT,
    input  logic [WINBITS-1:0] WINDOW_LEN,
    input  logic [3:0]         OFFSET,
    input  logic               VALID_IN,
    output logic [3:0]         CARRYIN,
    output logic [NSTAGES-1:0] STAGE_CE,
    output logic               ACC_CE,
    output logic               ACC_LOAD,
    output logic               SUM_VALID,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WINBITS:0]        cnt_q, cnt_d;
    logic [WINBITS:0]        len_q, len_d;
    logic [3:0]              offset_q, offset_d;
    logic [PIPE_LATENCY-1:0] vld_q, vld_d;
    logic [PIPE_LATENCY-1:0] fst_q, fst_d;
    logic                    sum_valid_q, sum_valid_d;
    logic [WINBITS:0]        cnt_inc_s;
    logic                    last_token_s;

    assign cnt_inc_s    = cnt_q + {{WINBITS{1'b0}}, 1'b1};
    // The youngest token sits at the accumulator input with nothing behind it.
    assign last_token_s = vld_q[PIPE_LATENCY-1] && (vld_q[PIPE_LATENCY-2:0] == {(PIPE_LATENCY-1){1'b0}});

    // Next-state, counter, latched config and token pipeline
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        offset_d    = offset_q;
        vld_d       = {vld_q[PIPE_LATENCY-2:0], 1'b0};
        fst_d       = {fst_q[PIPE_LATENCY-2:0], 1'b0};
        sum_valid_d = 1'b0;
        if (ABORT) begin
            state_d  = IDLE;
            cnt_d    = {(WINBITS+1){1'b0}};
            len_d    = {(WINBITS+1){1'b0}};
            offset_d = 4'd0;
            vld_d    = {PIPE_LATENCY{1'b0}};
            fst_d    = {PIPE_LATENCY{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        // A zero length stands for a full 2^WINBITS window.
                        len_d    = (WINDOW_LEN == {WINBITS{1'b0}}) ? {1'b1, {WINBITS{1'b0}}}
                                                                   : {1'b0, WINDOW_LEN};
                        offset_d = OFFSET;
                        cnt_d    = {(WINBITS+1){1'b0}};
                        state_d  = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (VALID_IN) begin
                        vld_d[0] = 1'b1;
                        fst_d[0] = (cnt_q == {(WINBITS+1){1'b0}});
                        cnt_d    = cnt_inc_s;
                        if (cnt_inc_s == len_q) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (last_token_s) begin
                        sum_valid_d = 1'b1;
                        cnt_d       = {(WINBITS+1){1'b0}};
                        state_d     = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {(WINBITS+1){1'b0}};
            len_q       <= {(WINBITS+1){1'b0}};
            offset_q    <= 4'd0;
            vld_q       <= {PIPE_LATENCY{1'b0}};
            fst_q       <= {PIPE_LATENCY{1'b0}};
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            offset_q    <= offset_d;
            vld_q       <= vld_d;
            fst_q       <= fst_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    // Bubbles and aborted cycles must not inject the carry-in offset.
    assign CARRYIN   = ((state_q == RUN) && VALID_IN && !ABORT) ? offset_q : 4'd0;
    assign STAGE_CE  = vld_q[PIPE_LATENCY-1:1];
    assign ACC_CE    = vld_q[PIPE_LATENCY-1];
    assign ACC_LOAD  = fst_q[PIPE_LATENCY-1];
    assign SUM_VALID = sum_valid_q;
    assign BUSY      = (state_q != IDLE);

endmodule
